// File: rtl/ddr_cmd_pkg.sv
// Shared types and constants for the DDR4 command scheduler: FSM states,
// internal command kinds, ras/cas/we encodings and default timings.
package ddr_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    PRE_WAIT,
    ACT,
    ACT_WAIT,
    CAS,
    RPREA,
    RPREA_WAIT,
    RREF,
    RREF_WAIT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_ACT,
    C_CAS,
    C_PRE,
    C_PREA,
    C_REF
  } cmd_t;

  // {ras_n, cas_n, we_n} as carried on A16/A15/A14 while act_n is high
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_REF = 3'b001;

  localparam int DEF_TRCD  = 4;
  localparam int DEF_TRP   = 4;
  localparam int DEF_TRFC  = 16;
  localparam int DEF_TREFI = 1000;

endpackage

// File: rtl/open_row_table.sv
// Per-bank open-row tracker: one valid bit and row address per bank, with a
// combinational lookup port and a single registered update port.
module open_row_table #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BGWIDTH+BAWIDTH-1:0] lookup_idx,
  input  logic [ADDRWIDTH-1:0]       lookup_row,
  output logic                       lookup_valid,
  output logic                       lookup_hit,
  output logic                       any_open,
  input  logic                       set_en,
  input  logic                       clear_en,
  input  logic                       clear_all,
  input  logic [BGWIDTH+BAWIDTH-1:0] update_idx,
  input  logic [ADDRWIDTH-1:0]       update_row
);

  localparam int NBANKS = 1 << (BGWIDTH + BAWIDTH);

  logic [NBANKS-1:0]    valid;
  logic [ADDRWIDTH-1:0] rows [NBANKS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (set_en) begin
      valid[update_idx] <= 1'b1;
    end else if (clear_en) begin
      valid[update_idx] <= 1'b0;
    end
  end

  // Row storage needs no reset: an entry is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (set_en) begin
      rows[update_idx] <= update_row;
    end
  end

  assign lookup_valid = valid[lookup_idx];
  assign lookup_hit   = valid[lookup_idx] && (rows[lookup_idx] == lookup_row);
  assign any_open     = |valid;

endmodule

// File: rtl/cmd_scheduler.sv
// DDR4 command scheduler: turns single read/write requests into PRE/ACT/RD/WR
// sequences using an open-row table, and interleaves periodic refresh.
module cmd_scheduler
  import ddr_cmd_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = DEF_TRCD,
  parameter int TRP       = DEF_TRP,
  parameter int TRFC      = DEF_TRFC,
  parameter int TREFI     = DEF_TREFI
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 cs_n,
  output logic                 cke,
  output logic                 cas_issued,
  output logic                 cas_wr
);

  localparam logic [7:0]  TRCD_LOAD  = 8'(TRCD - 1);
  localparam logic [7:0]  TRP_LOAD   = 8'(TRP - 1);
  localparam logic [7:0]  TRFC_LOAD  = 8'(TRFC);
  localparam logic [15:0] TREFI_LOAD = 16'(TREFI - 1);

  state_t state, state_next;
  cmd_t   cmd;
  logic [7:0]  cnt, cnt_next;
  logic [15:0] ref_timer;
  logic        ref_pending;

  logic                 lat_wr;
  logic [BGWIDTH-1:0]   lat_bg;
  logic [BAWIDTH-1:0]   lat_ba;
  logic [ADDRWIDTH-1:0] lat_row;
  logic [COLWIDTH-1:0]  lat_col;

  logic                 cur_wr;
  logic [BGWIDTH-1:0]   cur_bg;
  logic [BAWIDTH-1:0]   cur_ba;
  logic [ADDRWIDTH-1:0] cur_row;
  logic [COLWIDTH-1:0]  cur_col;

  logic lookup_valid, lookup_hit, any_open;
  logic                 nxt_cs_n, nxt_act_n, nxt_cas, nxt_cas_wr;
  logic [ADDRWIDTH-1:0] nxt_a;
  logic [BGWIDTH-1:0]   nxt_bg;
  logic [BAWIDTH-1:0]   nxt_ba;

  assign req_ready = (state == IDLE) && !ref_pending && cke;

  // The first command of a request is issued from IDLE in the accept cycle,
  // before the latch holds it, so addressing comes straight from the inputs there.
  assign cur_wr  = (state == IDLE) ? req_wr  : lat_wr;
  assign cur_bg  = (state == IDLE) ? req_bg  : lat_bg;
  assign cur_ba  = (state == IDLE) ? req_ba  : lat_ba;
  assign cur_row = (state == IDLE) ? req_row : lat_row;
  assign cur_col = (state == IDLE) ? req_col : lat_col;

  open_row_table #(
    .BGWIDTH  (BGWIDTH),
    .BAWIDTH  (BAWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_table (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_idx  ({req_bg, req_ba}),
    .lookup_row  (req_row),
    .lookup_valid(lookup_valid),
    .lookup_hit  (lookup_hit),
    .any_open    (any_open),
    .set_en      (cmd == C_ACT),
    .clear_en    (cmd == C_PRE),
    .clear_all   ((cmd == C_PREA) || (cmd == C_REF)),
    .update_idx  ({cur_bg, cur_ba}),
    .update_row  (cur_row)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cmd        = C_NONE;
    case (state)
      IDLE: begin
        if (ref_pending) begin
          cmd        = any_open ? C_PREA : C_REF;
          state_next = any_open ? RPREA : RREF;
        end else if (req_valid && req_ready) begin
          if (lookup_hit) begin
            cmd = C_CAS; state_next = CAS;
          end else if (lookup_valid) begin
            cmd = C_PRE; state_next = PRE;
          end else begin
            cmd = C_ACT; state_next = ACT;
          end
        end
      end
      PRE, RPREA: begin
        if (TRP > 1) begin
          cnt_next   = TRP_LOAD;
          state_next = (state == PRE) ? PRE_WAIT : RPREA_WAIT;
        end else begin
          cmd        = (state == PRE) ? C_ACT : C_REF;
          state_next = (state == PRE) ? ACT : RREF;
        end
      end
      PRE_WAIT, RPREA_WAIT: begin
        if (cnt == 8'd1) begin
          cmd        = (state == PRE_WAIT) ? C_ACT : C_REF;
          state_next = (state == PRE_WAIT) ? ACT : RREF;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      ACT: begin
        if (TRCD > 1) begin
          cnt_next = TRCD_LOAD; state_next = ACT_WAIT;
        end else begin
          cmd = C_CAS; state_next = CAS;
        end
      end
      ACT_WAIT: begin
        if (cnt == 8'd1) begin
          cmd = C_CAS; state_next = CAS;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      CAS: state_next = IDLE;
      RREF: begin
        if (TRFC > 0) begin
          cnt_next = TRFC_LOAD; state_next = RREF_WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      RREF_WAIT: begin
        if (cnt == 8'd1) state_next = IDLE;
        else             cnt_next = cnt - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin image of the command chosen this cycle; everything unlisted stays 0.
  always_comb begin
    nxt_cs_n   = 1'b1;
    nxt_act_n  = 1'b1;
    nxt_a      = '0;
    nxt_bg     = '0;
    nxt_ba     = '0;
    nxt_cas    = 1'b0;
    nxt_cas_wr = 1'b0;
    case (cmd)
      C_ACT: begin
        nxt_cs_n = 1'b0; nxt_act_n = 1'b0; nxt_a = cur_row;
        nxt_bg = cur_bg; nxt_ba = cur_ba;
      end
      C_CAS: begin
        nxt_cs_n = 1'b0;
        nxt_a[ADDRWIDTH-1 -: 3] = cur_wr ? RCW_WR : RCW_RD;
        nxt_a[COLWIDTH-1:0]     = cur_col;
        nxt_bg = cur_bg; nxt_ba = cur_ba;
        nxt_cas = 1'b1; nxt_cas_wr = cur_wr;
      end
      C_PRE: begin
        nxt_cs_n = 1'b0; nxt_a[ADDRWIDTH-1 -: 3] = RCW_PRE;
        nxt_bg = cur_bg; nxt_ba = cur_ba;
      end
      C_PREA: begin
        nxt_cs_n = 1'b0; nxt_a[ADDRWIDTH-1 -: 3] = RCW_PRE; nxt_a[10] = 1'b1;
      end
      C_REF: begin
        nxt_cs_n = 1'b0; nxt_a[ADDRWIDTH-1 -: 3] = RCW_REF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cke        <= 1'b0;
      cs_n       <= 1'b1;
      act_n      <= 1'b1;
      A          <= '0;
      bg         <= '0;
      ba         <= '0;
      cas_issued <= 1'b0;
      cas_wr     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cke        <= 1'b1;
      cs_n       <= nxt_cs_n;
      act_n      <= nxt_act_n;
      A          <= nxt_a;
      bg         <= nxt_bg;
      ba         <= nxt_ba;
      cas_issued <= nxt_cas;
      cas_wr     <= nxt_cas_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_wr  <= 1'b0;
      lat_bg  <= '0;
      lat_ba  <= '0;
      lat_row <= '0;
      lat_col <= '0;
    end else if (req_valid && req_ready) begin
      lat_wr  <= req_wr;
      lat_bg  <= req_bg;
      lat_ba  <= req_ba;
      lat_row <= req_row;
      lat_col <= req_col;
    end
  end

  // A fresh expiry wins over a REF issued in the same cycle so no interval is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_timer   <= TREFI_LOAD;
      ref_pending <= 1'b0;
    end else if (ref_timer == 16'd0) begin
      ref_timer   <= TREFI_LOAD;
      ref_pending <= 1'b1;
    end else begin
      ref_timer <= ref_timer - 16'd1;
      if (cmd == C_REF) ref_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: a transaction-level schedule model
// predicts the pins of every cycle for directed and random request streams.
module tb_cmd_scheduler;

  localparam int BGW = 2, BAW = 2, AW = 17, CW = 10;
  localparam int TRCD = 4, TRP = 4, TRFC = 16, TREFI = 50;
  localparam int K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_PREA = 5, K_REF = 6;
  localparam logic [24:0] DESEL = {1'b1, 1'b1, 17'd0, 2'd0, 2'd0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic req_valid = 1'b0, req_wr = 1'b0;
  logic [BGW-1:0] req_bg = '0;
  logic [BAW-1:0] req_ba = '0;
  logic [AW-1:0]  req_row = '0;
  logic [CW-1:0]  req_col = '0;
  logic req_ready, act_n, cs_n, cke, cas_issued, cas_wr;
  logic [AW-1:0]  A;
  logic [BGW-1:0] bg;
  logic [BAW-1:0] ba;

  cmd_scheduler #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
    .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TREFI(TREFI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .act_n(act_n), .A(A), .bg(bg), .ba(ba), .cs_n(cs_n),
    .cke(cke), .cas_issued(cas_issued), .cas_wr(cas_wr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cycle index since reset release, first free cycle, refresh flag,
  // open-row table and the absolute cycle each predicted command hits the pins.
  int cyc, busy_until, clr_edge;
  bit pend;
  bit open_v [16];
  int open_row [16];
  logic [24:0] exp_cmd [int];

  wire [26:0] obs = {cs_n, act_n, A, bg, ba, cas_issued, cas_wr, cke, req_ready};

  function automatic logic [24:0] mk(input int kind, input int g, input int b, input int row, input int col);
    logic [AW-1:0] a;
    logic act, cas, wr;
    logic [BGW-1:0] gg;
    logic [BAW-1:0] bb;
    a = '0; act = 1'b1; cas = 1'b0; wr = 1'b0; gg = g[BGW-1:0]; bb = b[BAW-1:0];
    case (kind)
      K_ACT: begin act = 1'b0; a = row[AW-1:0]; end
      K_RD, K_WR: begin
        a[16] = 1'b1; a[14] = (kind == K_RD); a[CW-1:0] = col[CW-1:0];
        cas = 1'b1; wr = (kind == K_WR);
      end
      K_PRE: a[15] = 1'b1;
      K_PREA: begin a[15] = 1'b1; a[10] = 1'b1; gg = '0; bb = '0; end
      K_REF: begin a[14] = 1'b1; gg = '0; bb = '0; end
      default: ;
    endcase
    return {1'b0, act, a, gg, bb, cas, wr};
  endfunction

  function automatic logic [26:0] exp_now();
    logic [24:0] c;
    c = exp_cmd.exists(cyc) ? exp_cmd[cyc] : DESEL;
    return {c, cyc >= 1, (cyc >= 1) && (cyc >= busy_until) && !pend};
  endfunction

  task automatic do_reset();
    req_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0; busy_until = 1; pend = 1'b0; clr_edge = -1;
    exp_cmd.delete();
    foreach (open_v[i]) open_v[i] = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model past the edge, land on the next negedge.
  task automatic step(input bit v, input bit w, input int g, input int b, input int r, input int c);
    int idx, t;
    bit idle, any;
    req_valid = v; req_wr = w; req_bg = g[BGW-1:0]; req_ba = b[BAW-1:0];
    req_row = r[AW-1:0]; req_col = c[CW-1:0];
    idle = (cyc >= 1) && (cyc >= busy_until);
    if (idle && pend) begin
      any = 1'b0;
      foreach (open_v[i]) any |= open_v[i];
      t = cyc + 1;
      if (any) begin exp_cmd[t] = mk(K_PREA, 0, 0, 0, 0); t += TRP; end
      exp_cmd[t] = mk(K_REF, 0, 0, 0, 0);
      clr_edge = t - 1;
      busy_until = t + TRFC + 1;
      foreach (open_v[i]) open_v[i] = 1'b0;
    end else if (idle && v) begin
      idx = g * (1 << BAW) + b;
      t = cyc + 1;
      if (!(open_v[idx] && open_row[idx] == r)) begin
        if (open_v[idx]) begin exp_cmd[t] = mk(K_PRE, g, b, 0, 0); t += TRP; end
        exp_cmd[t] = mk(K_ACT, g, b, r, 0); t += TRCD;
        open_v[idx] = 1'b1; open_row[idx] = r;
      end
      exp_cmd[t] = mk(w ? K_WR : K_RD, g, b, 0, c);
      busy_until = t + 1;
    end
    if (cyc == clr_edge) pend = 1'b0;
    if ((cyc + 1) % TREFI == 0) pend = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== {DESEL, 2'b00}) begin
      fails++; $display("[TB] FAIL reset_hold pins actual=%h required=%h", obs, {DESEL, 2'b00});
    end
    do_reset();
    tests++;
    if (obs !== exp_now()) begin
      fails++; $display("[TB] FAIL reset_release pins actual=%h required=%h", obs, exp_now());
    end
    repeat (2) begin
      step(0, 0, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL reset_idle cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
    end
  endtask

  task automatic test_closed_read();
    int cas_cyc = -1;
    int t_acc;
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    t_acc = cyc;
    step(1, 0, 1, 2, 'h55, 'h10);
    repeat (9) begin
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL closed_read cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      if (cas_issued === 1'b1 && cas_cyc < 0) cas_cyc = cyc;
      step(0, 0, 0, 0, 0, 0);
    end
    tests++;
    if (cas_cyc != t_acc + 1 + TRCD) begin
      fails++; $display("[TB] FAIL closed_read_cas_cycle actual=%0d required=%0d", cas_cyc, t_acc + 1 + TRCD);
    end
  endtask

  task automatic test_hit_write();
    int acts = 0;
    step(1, 1, 1, 2, 'h55, 'h20);
    repeat (3) begin
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL hit_write cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      if (act_n === 1'b0) acts++;
      step(0, 0, 0, 0, 0, 0);
    end
    tests++;
    if (acts != 0) begin
      fails++; $display("[TB] FAIL hit_write_no_act actual=%0d required=0", acts);
    end
  endtask

  task automatic test_conflict();
    step(1, 0, 1, 2, 'h66, $urandom_range(0, 1023));
    repeat (11) begin
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL conflict cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_refresh();
    int low = 0;
    while (cyc < 80) begin
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL refresh cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      if (req_ready === 1'b0) low++;
      step(0, 0, 0, 0, 0, 0);
    end
    tests++;
    if (low != 1 + TRP + TRFC + 1) begin
      fails++; $display("[TB] FAIL refresh_ready_low actual=%0d required=%0d", low, 1 + TRP + TRFC + 1);
    end
    step(1, 0, 1, 2, 'h66, 'h1);
    tests++;
    if (act_n !== 1'b0) begin
      fails++; $display("[TB] FAIL refresh_table_empty act_n actual=%b required=0", act_n);
    end
    repeat (6) begin
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL refresh_after cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_refresh_during_act();
    int cas_cyc = -1, prea_cyc = -1;
    do_reset();
    while (cyc < 46) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 'h123, 'h3f);
    repeat (30) begin
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL refresh_in_act cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      if (cas_issued === 1'b1 && cas_cyc < 0) cas_cyc = cyc;
      if (cs_n === 1'b0 && A[10] === 1'b1 && A[15] === 1'b1 && prea_cyc < 0) prea_cyc = cyc;
      step(0, 0, 0, 0, 0, 0);
    end
    tests++;
    if (cas_cyc != 51 || prea_cyc != 53) begin
      fails++; $display("[TB] FAIL refresh_in_act_order cas=%0d prea=%0d required cas=51 prea=53", cas_cyc, prea_cyc);
    end
  endtask

  task automatic test_reset_in_pre_wait();
    int acts = 0;
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 2, 3, 7, 5);
    while (cyc < 7) step(0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 3, 9, 6);
    step(0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== {DESEL, 2'b00}) begin
      fails++; $display("[TB] FAIL reset_async pins actual=%h required=%h", obs, {DESEL, 2'b00});
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== {DESEL, 2'b00}) begin
        fails++; $display("[TB] FAIL reset_held pins actual=%h required=%h", obs, {DESEL, 2'b00});
      end
    end
    do_reset();
    repeat (12) begin
      step(0, 0, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL reset_abandon cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
      if (act_n === 1'b0) acts++;
    end
    tests++;
    if (acts != 0) begin
      fails++; $display("[TB] FAIL reset_no_act actual=%0d required=0", acts);
    end
    step(1, 0, 2, 3, 9, 4);
    tests++;
    if (act_n !== 1'b0 || A !== 17'd9) begin
      fails++; $display("[TB] FAIL reset_bank_closed act_n=%b A=%h required act_n=0 A=9", act_n, A);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (700) begin
      step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1023));
      tests++;
      if (obs !== exp_now()) begin
        fails++; $display("[TB] FAIL random cyc=%0d pins actual=%h required=%h", cyc, obs, exp_now());
      end
    end
  endtask

  initial begin
    test_reset();
    test_closed_read();
    test_hit_write();
    test_conflict();
    test_refresh();
    test_refresh_during_act();
    test_reset_in_pre_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 BGWIDTH, 2, bank-group address width
 BAWIDTH, 2, bank address width
 ADDRWIDTH, 17, row/A-bus width
 COLWIDTH, 10, column width
 TRCD, 4, ACT-to-CAS cycles
 TRP, 4, PRE-to-ACT/REF cycles
 TRFC, 16, REF-to-next-command cycles
 TREFI, 1000, refresh interval cycles
REQ-002 Ports (name, direction, width, meaning), one per line; single clock clk; reset_n asynchronous, active-low:
 clk  in  1  sole clock
 reset_n  in  1  async active-low reset
 req_valid  in  1  request present
 req_ready  out  1  request accepted when req_valid and req_ready are both high
 req_wr  in  1  1=write, 0=read
 req_bg  in  BGWIDTH  bank group
 req_ba  in  BAWIDTH  bank
 req_row  in  ADDRWIDTH  row
 req_col  in  COLWIDTH  column
 act_n  out  1  DDR4 activate
 A  out  ADDRWIDTH  row address / command bits (A16=ras_n, A15=cas_n, A14=we_n)
 bg  out  BGWIDTH  bank group
 ba  out  BAWIDTH  bank
 cs_n  out  1  chip select
 cke  out  1  clock enable
 cas_issued  out  1  one-cycle pulse when RD/WR is on the pins
 cas_wr  out  1  valid with cas_issued; 1=WR

Function
REQ-003 All command outputs SHALL be registered; at most one command per cycle; deselect = cs_n=1, act_n=1, A=0, bg=0, ba=0.
REQ-004 ACT: cs_n=0, act_n=0, A=row. RD: cs_n=0, act_n=1, A16=1, A15=0, A14=1, A10=0, A[COLWIDTH-1:0]=col. WR: as RD with A14=0. PRE: A16=0, A15=1, A14=0, A10=0. PREA: as PRE with A10=1. REF: A16=0, A15=0, A14=1. All unlisted A bits SHALL be 0.
REQ-005 FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS, RPREA, RPREA_WAIT, RREF, RREF_WAIT.
REQ-006 req_ready SHALL be 1 only in IDLE with ref_pending=0; an accepted request SHALL be latched.
REQ-007 Open-row table: one valid bit plus row per bank (2^(BGWIDTH+BAWIDTH) entries). ACT SHALL set the entry; PRE SHALL clear it; PREA and REF SHALL clear all entries.
REQ-008 Accept in cycle T; the first command SHALL be on the pins in T+1:
 - hit (valid, same row): CAS at T+1
 - closed: ACT at T+1, CAS at T+1+TRCD
 - conflict (valid, other row): PRE at T+1, ACT at T+1+TRP, CAS at T+1+TRP+TRCD
REQ-009 Wait states SHALL drive deselect and count down the timing parameter with an 8-bit counter; the FSM SHALL return to IDLE in the cycle after CAS.
REQ-010 Refresh timer (16-bit) SHALL decrement every cycle and reload TREFI-1 on reaching 0; on reaching 0 it SHALL set ref_pending. Expiry while ref_pending is already set SHALL be dropped.
REQ-011 In IDLE with ref_pending=1, refresh SHALL take priority over req_valid:
 - any bank open: PREA, wait TRP, REF, wait TRFC
 - none open: REF, wait TRFC
 ref_pending SHALL clear when REF issues; the FSM SHALL return to IDLE after TRFC.
REQ-012 ref_pending asserted during a request sequence SHALL NOT abort it; refresh SHALL start at the next IDLE.
REQ-013 cas_issued/cas_wr SHALL be asserted in exactly the cycle RD/WR is driven.

Reset
REQ-014 reset_n low SHALL immediately force: deselect outputs, cke=0, req_ready=0, cas_issued=0, state=IDLE, open-row table cleared, ref_pending=0, refresh timer=TREFI-1.
REQ-015 cke SHALL rise in the first clk edge after reset_n deasserts; reset during any wait state SHALL abandon the sequence without issuing further commands.

Structure
REQ-016 Shared package ddr_cmd_pkg SHALL hold the state enum, the command encodings of REQ-004 (ras/cas/we triples), and the default timing constants.
REQ-017 The open-row table SHALL be the sub-module open_row_table (lookup: hit/valid; update: set/clear/clear-all).

Verification
REQ-018 After reset, RD bg=1 ba=2 row=0x55 col=0x10 -> ACT (A=0x55) at T+1, RD with A[9:0]=0x10 at T+5, cas_issued=1, cas_wr=0.
REQ-019 Repeat WR to the same bank/row col=0x20 -> WR at T+1 with no ACT; cas_wr=1.
REQ-020 RD bg=1 ba=2 row=0x66 -> PRE at T+1, ACT row=0x66 at T+5, RD at T+9.
REQ-021 TREFI=50 with one bank open -> PREA (A10=1) then REF 4 cycles later, req_ready=0 for 4+16+2 cycles, table empty afterwards.
REQ-022 Refresh expires during ACT_WAIT -> CAS still at the scheduled cycle, then PREA/REF sequence.
REQ-023 reset_n pulsed low during PRE_WAIT -> outputs deselect asynchronously, no ACT follows, next request to that bank is treated as closed.
